// File: rtl/output_buffer.sv
// output_buffer
//   Router output-port stage behind the round-robin arbiter. It closes the
//   arbiter's 4-phase req/ack handshake and captures the selected channel's
//   flit into a DEPTH-entry FIFO. A second, independent 4-phase handshake
//   drains the FIFO to the next link, so link back-pressure never stalls
//   arbitration beyond FIFO capacity.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset (discards FIFO contents)
//   req_in    request from arbiter
//   ack_in    acknowledge to arbiter (registered)
//   selected  channel index chosen by the arbiter
//   data_in   COUNT flits, channel k at [k*SIZE +: SIZE]
//   req_out   request to next link (registered)
//   ack_out   acknowledge from next link
//   data_out  flit presented to next link (registered)
//   count     FIFO occupancy
//
// Optional build macro
//   OUTPUT_BUFFER_TRACE_EN : prints push/pop trace messages in simulation.
module output_buffer #(
  parameter int COUNT      = 5,
  parameter int COUNT_BITS = 3,
  parameter int SIZE       = 8,
  parameter int DEPTH      = 4,
  parameter int DEPTH_BITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_in,
  output logic                    ack_in,
  input  logic [COUNT_BITS-1:0]   selected,
  input  logic [COUNT*SIZE-1:0]   data_in,
  output logic                    req_out,
  input  logic                    ack_out,
  output logic [SIZE-1:0]         data_out,
  output logic [DEPTH_BITS:0]     count
);

  localparam logic [DEPTH_BITS:0] FULL = (DEPTH_BITS+1)'(DEPTH);

  typedef enum logic       {IN_IDLE, IN_HOLD} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_WAIT_ACK, OUT_WAIT_LOW} out_state_e;

  in_state_e             in_q, in_d;
  out_state_e            out_q, out_d;
  logic                  ack_in_q, ack_in_d;
  logic                  req_out_q, req_out_d;
  logic [SIZE-1:0]       data_out_q, data_out_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [SIZE-1:0]       mem_q [DEPTH];
  logic                  push, pop;
  logic [SIZE-1:0]       wr_flit;

  // Channel mux; an out-of-range index matches no channel and yields zero.
  always_comb begin
    wr_flit = '0;
    for (int k = 0; k < COUNT; k++)
      if (selected == COUNT_BITS'(k)) wr_flit = data_in[k*SIZE +: SIZE];
  end

  // Input side: capture on request when not full, hold ack until req drops.
  always_comb begin
    in_d     = in_q;
    ack_in_d = ack_in_q;
    push     = 1'b0;
    case (in_q)
      IN_IDLE: if (req_in && (count_q < FULL)) begin
        push     = 1'b1;
        ack_in_d = 1'b1;
        in_d     = IN_HOLD;
      end
      IN_HOLD: if (!req_in) begin
        ack_in_d = 1'b0;
        in_d     = IN_IDLE;
      end
      default: begin
        ack_in_d = 1'b0;
        in_d     = IN_IDLE;
      end
    endcase
  end

  // Output side: present head entry, pop on ack, wait for ack to drop.
  always_comb begin
    out_d      = out_q;
    req_out_d  = req_out_q;
    data_out_d = data_out_q;
    pop        = 1'b0;
    case (out_q)
      OUT_IDLE: if (count_q != '0) begin
        data_out_d = mem_q[rd_ptr_q];
        req_out_d  = 1'b1;
        out_d      = OUT_WAIT_ACK;
      end
      OUT_WAIT_ACK: if (ack_out) begin
        pop       = 1'b1;
        req_out_d = 1'b0;
        out_d     = OUT_WAIT_LOW;
      end
      OUT_WAIT_LOW: if (!ack_out) out_d = OUT_IDLE;
      default: begin
        req_out_d = 1'b0;
        out_d     = OUT_IDLE;
      end
    endcase
  end

  // Full check above used count_q, so a same-cycle pop never frees a slot
  // for this cycle's push; count therefore stays within 0..DEPTH.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q       <= IN_IDLE;
      out_q      <= OUT_IDLE;
      ack_in_q   <= 1'b0;
      req_out_q  <= 1'b0;
      data_out_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      in_q       <= in_d;
      out_q      <= out_d;
      ack_in_q   <= ack_in_d;
      req_out_q  <= req_out_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef OUTPUT_BUFFER_TRACE_EN
      if (push) $display("%0t push channel %0d count %0d", $time, selected, count_d);
      if (pop)  $display("%0t pop count %0d", $time, count_d);
`endif
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= wr_flit;
  end

  assign ack_in   = ack_in_q;
  assign req_out  = req_out_q;
  assign data_out = data_out_q;
  assign count    = count_q;

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: reset, single transfer, fill to full,
// ordering with pointer wrap, simultaneous push/pop, out-of-range channel
// and reset in the middle of both handshakes.
module tb_output_buffer;
  localparam int COUNT = 5, COUNT_BITS = 3, SIZE = 8, DEPTH = 4, DEPTH_BITS = 2;

  logic                  clk = 1'b0;
  logic                  reset, req_in, ack_out;
  logic                  ack_in, req_out;
  logic [COUNT_BITS-1:0] selected;
  logic [COUNT*SIZE-1:0] data_in;
  logic [SIZE-1:0]       data_out;
  logic [DEPTH_BITS:0]   count;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  output_buffer #(.COUNT(COUNT), .COUNT_BITS(COUNT_BITS), .SIZE(SIZE),
                  .DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .ack_in(ack_in),
    .selected(selected), .data_in(data_in), .req_out(req_out),
    .ack_out(ack_out), .data_out(data_out), .count(count));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_in = 1'b0; ack_out = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push_flit(input int sel, input logic [7:0] val, input string tag);
    int n;
    selected = sel[COUNT_BITS-1:0];
    if (sel < COUNT) data_in[sel*SIZE +: SIZE] = val;
    req_in = 1'b1;
    n = 0;
    while (!ack_in && n < 20) begin tick(); n++; end
    chk({tag, "_ack"}, ack_in, 1);
    req_in = 1'b0;
    n = 0;
    while (ack_in && n < 20) begin tick(); n++; end
    chk({tag, "_ackfall"}, ack_in, 0);
  endtask

  task automatic pop_flit(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (!req_out && n < 20) begin tick(); n++; end
    chk({tag, "_req"}, req_out, 1);
    chk(tag, data_out, exp);
    ack_out = 1'b1;
    tick();
    chk({tag, "_reqfall"}, req_out, 0);
    ack_out = 1'b0;
    tick();
  endtask

  initial begin
    selected = '0; data_in = '0;
    do_reset();
    chk("rst_ack_in", ack_in, 0);
    chk("rst_req_out", req_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_count", count, 0);

    // Single transfer, cycle-exact.
    selected = 3'd2; data_in[2*SIZE +: SIZE] = 8'hA5; req_in = 1'b1;
    tick();
    chk("single_ack_rise", ack_in, 1);
    chk("single_count1", count, 1);
    chk("single_req_early", req_out, 0);
    req_in = 1'b0;
    tick();
    chk("single_ack_fall", ack_in, 0);
    chk("single_req_rise", req_out, 1);
    chk("single_data", data_out, 8'hA5);
    ack_out = 1'b1;
    tick();
    chk("single_req_fall", req_out, 0);
    chk("single_count0", count, 0);
    ack_out = 1'b0;
    tick();

    // Fill to full with the link stalled.
    do_reset();
    for (int i = 0; i < 4; i++) push_flit(i, 8'(i + 1), "fill");
    chk("fill_count4", count, 4);
    selected = 3'd4; data_in[4*SIZE +: SIZE] = 8'h05; req_in = 1'b1;
    tick(); tick(); tick();
    chk("full_no_ack", ack_in, 0);
    chk("full_count", count, 4);
    chk("full_head_req", req_out, 1);
    chk("full_head_data", data_out, 8'h01);
    ack_out = 1'b1;
    tick();
    chk("full_pop_count", count, 3);
    chk("full_pop_no_push", ack_in, 0);
    ack_out = 1'b0;
    tick();
    chk("full_late_ack", ack_in, 1);
    chk("full_late_count", count, 4);
    req_in = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) pop_flit(8'(i), "fill_drain");
    chk("fill_empty", count, 0);

    // Ordering across pointer wrap.
    do_reset();
    for (int i = 0; i < 3; i++) push_flit(i % COUNT, 8'(8'h10 + i), "wrap_push");
    for (int i = 3; i < 10; i++) begin
      push_flit(i % COUNT, 8'(8'h10 + i), "wrap_push");
      pop_flit(8'(8'h10 + i - 3), "wrap_pop");
    end
    for (int i = 7; i < 10; i++) pop_flit(8'(8'h10 + i), "wrap_pop");
    chk("wrap_empty", count, 0);

    // Push and pop on the same edge.
    do_reset();
    push_flit(0, 8'h21, "pp_push");
    push_flit(1, 8'h22, "pp_push");
    chk("pp_count2", count, 2);
    chk("pp_req", req_out, 1);
    selected = 3'd3; data_in[3*SIZE +: SIZE] = 8'h23;
    req_in = 1'b1; ack_out = 1'b1;
    tick();
    chk("pp_count_same", count, 2);
    chk("pp_ack_in", ack_in, 1);
    chk("pp_req_fall", req_out, 0);
    req_in = 1'b0; ack_out = 1'b0;
    tick();
    pop_flit(8'h22, "pp_drain");
    pop_flit(8'h23, "pp_drain");
    chk("pp_empty", count, 0);

    // Out-of-range channel index captures zero.
    data_in = '1;
    push_flit(7, 8'hFF, "oor");
    pop_flit(8'h00, "oor_data");

    // Reset while both handshakes are mid-flight.
    do_reset();
    selected = 3'd1; data_in[1*SIZE +: SIZE] = 8'h33; req_in = 1'b1;
    tick(); tick();
    chk("mid_ack_hi", ack_in, 1);
    chk("mid_req_hi", req_out, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_ack", ack_in, 0);
    chk("mid_rst_req", req_out, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_count", count, 0);
    reset = 1'b0; req_in = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
